// File: rtl/branch_resolve.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve
//  Description : Execute-stage branch resolution for the BTB/global-history
//                predictor. Carries each fetched instruction's prediction
//                through decode (stage 2) into execute (stage 3). In stage 3
//                it resolves the real outcome and target, flags mispredicts,
//                and keeps saturating branch/mispredict counters.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst_n          clock, asynchronous active-low reset
//    memory_stall        freezes all pipeline registers and counters
//    flush               squashes the wrong-path instructions in stages 1-2
//    pc_1, instr_1       fetch-stage PC and instruction word
//    pred_taken_1        predicted direction for pc_1
//    pred_target_1       predicted target for pc_1
//    rs1_data_3/rs2_data_3  forwarded operands of the stage-3 instruction
//    instructionPC_3     stage-3 PC (registered)
//    is_branchInst_3     stage-3 holds a valid conditional branch or JAL
//    taken_3             resolved direction (combinational)
//    prev_taken_3        prediction carried with the stage-3 instruction
//    target_3            correct next PC (combinational)
//    mispredict_3        direction or target mispredicted (combinational)
//    branch_cnt          saturating count of retired branches
//    mispred_cnt         saturating count of retired mispredicts
// ============================================================================
module branch_resolve #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             memory_stall,
    input  logic             flush,
    input  logic [31:0]      pc_1,
    input  logic [31:0]      instr_1,
    input  logic             pred_taken_1,
    input  logic [31:0]      pred_target_1,
    input  logic [31:0]      rs1_data_3,
    input  logic [31:0]      rs2_data_3,
    output logic [31:0]      instructionPC_3,
    output logic             is_branchInst_3,
    output logic             taken_3,
    output logic             prev_taken_3,
    output logic [31:0]      target_3,
    output logic             mispredict_3,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam logic [6:0]       c_op_branch = 7'b1100011;
    localparam logic [6:0]       c_op_jal    = 7'b1101111;
    localparam logic [CNT_W-1:0] c_cnt_one   = {{(CNT_W-1){1'b0}}, 1'b1};

    // ---------------- stage 2 (decode) ----------------
    logic        r_s2_valid;
    logic [31:0] r_s2_pc;
    logic [31:0] r_s2_instr;
    logic        r_s2_pred_taken;
    logic [31:0] r_s2_pred_target;

    logic [6:0]  w_s2_opcode;
    logic [2:0]  w_s2_funct3;
    logic        w_s2_is_cond;
    logic        w_s2_is_jal;
    logic [31:0] w_s2_imm_b;
    logic [31:0] w_s2_imm_j;
    logic [31:0] w_s2_tgt;
    logic        w_s3_load;

    // ---------------- stage 3 (execute) ----------------
    logic        r_s3_valid;
    logic [31:0] r_s3_pc;
    logic [2:0]  r_s3_funct3;
    logic        r_s3_is_jal;
    logic        r_s3_is_br;
    logic        r_s3_pred_taken;
    logic [31:0] r_s3_pred_target;
    logic [31:0] r_s3_tgt;

    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    logic        w_eq;
    logic        w_lt_s;
    logic        w_lt_u;
    logic        w_cond_true;
    logic        w_taken;
    logic [31:0] w_target;
    logic        w_mispredict;

    // Decode in stage 2 so stage 3 only has the compare and a mux.
    assign w_s2_opcode  = r_s2_instr[6:0];
    assign w_s2_funct3  = r_s2_instr[14:12];
    // funct3 010/011 are not defined branch encodings and resolve as non-branches.
    assign w_s2_is_cond = (w_s2_opcode == c_op_branch) &&
                          (w_s2_funct3 != 3'b010) && (w_s2_funct3 != 3'b011);
    assign w_s2_is_jal  = (w_s2_opcode == c_op_jal);
    assign w_s2_imm_b   = {{19{r_s2_instr[31]}}, r_s2_instr[31], r_s2_instr[7],
                           r_s2_instr[30:25], r_s2_instr[11:8], 1'b0};
    assign w_s2_imm_j   = {{11{r_s2_instr[31]}}, r_s2_instr[31], r_s2_instr[19:12],
                           r_s2_instr[20], r_s2_instr[30:21], 1'b0};
    assign w_s2_tgt     = w_s2_is_jal  ? r_s2_pc + w_s2_imm_j :
                          w_s2_is_cond ? r_s2_pc + w_s2_imm_b :
                                         r_s2_pc + 32'd4;

    // Invalid stage-3 entries are loaded as all-zero so the registered
    // outputs can be driven straight from the stage-3 flops.
    assign w_s3_load = r_s2_valid & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid       <= 1'b0;
            r_s2_pc          <= '0;
            r_s2_instr       <= '0;
            r_s2_pred_taken  <= 1'b0;
            r_s2_pred_target <= '0;
            r_s3_valid       <= 1'b0;
            r_s3_pc          <= '0;
            r_s3_funct3      <= '0;
            r_s3_is_jal      <= 1'b0;
            r_s3_is_br       <= 1'b0;
            r_s3_pred_taken  <= 1'b0;
            r_s3_pred_target <= '0;
            r_s3_tgt         <= '0;
        end else if (!memory_stall) begin
            // Stage 1 is always valid; a flush turns it into a bubble.
            r_s2_valid       <= ~flush;
            r_s2_pc          <= pc_1;
            r_s2_instr       <= instr_1;
            r_s2_pred_taken  <= pred_taken_1;
            r_s2_pred_target <= pred_target_1;
            r_s3_valid       <= w_s3_load;
            r_s3_pc          <= w_s3_load ? r_s2_pc          : '0;
            r_s3_funct3      <= w_s3_load ? w_s2_funct3      : '0;
            r_s3_is_jal      <= w_s3_load & w_s2_is_jal;
            r_s3_is_br       <= w_s3_load & (w_s2_is_cond | w_s2_is_jal);
            r_s3_pred_taken  <= w_s3_load & r_s2_pred_taken;
            r_s3_pred_target <= w_s3_load ? r_s2_pred_target : '0;
            r_s3_tgt         <= w_s3_load ? w_s2_tgt         : '0;
        end
    end

    // ---------------- stage-3 resolution ----------------
    assign w_eq   = (rs1_data_3 == rs2_data_3);
    assign w_lt_s = ($signed(rs1_data_3) < $signed(rs2_data_3));
    assign w_lt_u = (rs1_data_3 < rs2_data_3);

    always_comb begin
        w_cond_true = 1'b0;
        case (r_s3_funct3)
            3'b000:  w_cond_true = w_eq;
            3'b001:  w_cond_true = ~w_eq;
            3'b100:  w_cond_true = w_lt_s;
            3'b101:  w_cond_true = ~w_lt_s;
            3'b110:  w_cond_true = w_lt_u;
            3'b111:  w_cond_true = ~w_lt_u;
            default: w_cond_true = 1'b0;
        endcase
    end

    assign w_taken      = r_s3_valid & (r_s3_is_jal | (r_s3_is_br & w_cond_true));
    assign w_target     = !r_s3_valid ? 32'd0 :
                          w_taken     ? r_s3_tgt : r_s3_pc + 32'd4;
    // A non-branch predicted taken mispredicts, steering the predictor back to pc+4.
    assign w_mispredict = r_s3_valid &
                          ((w_taken != r_s3_pred_taken) |
                           (w_taken & r_s3_pred_taken & (r_s3_pred_target != w_target)));

    // ---------------- performance counters ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (!memory_stall && r_s3_valid) begin
            if (r_s3_is_br && !(&r_branch_cnt)) begin
                r_branch_cnt <= r_branch_cnt + c_cnt_one;
            end
            if (w_mispredict && !(&r_mispred_cnt)) begin
                r_mispred_cnt <= r_mispred_cnt + c_cnt_one;
            end
        end
    end

    assign instructionPC_3 = r_s3_pc;
    assign is_branchInst_3 = r_s3_is_br;
    assign prev_taken_3    = r_s3_pred_taken;
    assign taken_3         = w_taken;
    assign target_3        = w_target;
    assign mispredict_3    = w_mispredict;
    assign branch_cnt      = r_branch_cnt;
    assign mispred_cnt     = r_mispred_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_resolve
//  Description : Self-checking bench for branch_resolve. A record-level
//                pipeline model with an arithmetic branch evaluator predicts
//                every output; directed cases pin the documented examples.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_branch_resolve;

    localparam int          CNT_W   = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pt;
        logic [31:0] ptgt;
    } rec_t;

    typedef struct packed {
        logic        is_br;
        logic        taken;
        logic [31:0] target;
        logic        mis;
    } res_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             memory_stall = 1'b0;
    logic             flush = 1'b0;
    logic [31:0]      pc_1 = '0;
    logic [31:0]      instr_1 = '0;
    logic             pred_taken_1 = 1'b0;
    logic [31:0]      pred_target_1 = '0;
    logic [31:0]      rs1_data_3 = '0;
    logic [31:0]      rs2_data_3 = '0;
    logic [31:0]      instructionPC_3;
    logic             is_branchInst_3;
    logic             taken_3;
    logic             prev_taken_3;
    logic [31:0]      target_3;
    logic             mispredict_3;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    int total = 0;
    int bad   = 0;

    rec_t m_s2, m_s3;
    int   m_br, m_mis;

    branch_resolve #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .memory_stall(memory_stall), .flush(flush),
        .pc_1(pc_1), .instr_1(instr_1), .pred_taken_1(pred_taken_1),
        .pred_target_1(pred_target_1), .rs1_data_3(rs1_data_3), .rs2_data_3(rs2_data_3),
        .instructionPC_3(instructionPC_3), .is_branchInst_3(is_branchInst_3),
        .taken_3(taken_3), .prev_taken_3(prev_taken_3), .target_3(target_3),
        .mispredict_3(mispredict_3), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    // Branch target as the ISA defines it: pc plus sign-extended offset.
    function automatic logic [31:0] br_target(input logic [31:0] pc, input logic [31:0] ins);
        int off;
        if (ins[6:0] == 7'b1101111)
            off = int'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        else if (ins[6:0] == 7'b1100011)
            off = int'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        else
            off = 4;
        return pc + off;
    endfunction

    function automatic res_t ref_eval(input rec_t r, input logic [31:0] a, input logic [31:0] b);
        res_t o;
        int   sa, sb;
        o = '0;
        if (!r.v) return o;
        sa = a;
        sb = b;
        if (r.instr[6:0] == 7'b1101111) begin
            o.is_br = 1'b1;
            o.taken = 1'b1;
        end else if (r.instr[6:0] == 7'b1100011 && r.instr[14:12] != 3'd2 && r.instr[14:12] != 3'd3) begin
            o.is_br = 1'b1;
            case (r.instr[14:12])
                3'd0:    o.taken = (a == b);
                3'd1:    o.taken = (a != b);
                3'd4:    o.taken = (sa < sb);
                3'd5:    o.taken = (sa >= sb);
                3'd6:    o.taken = (a < b);
                default: o.taken = (a >= b);
            endcase
        end
        o.target = o.taken ? br_target(r.pc, r.instr) : r.pc + 32'd4;
        o.mis    = (o.taken != r.pt) || (o.taken && r.pt && r.ptgt != o.target);
        return o;
    endfunction

    // Reference pipeline: records shift one stage per non-stalled edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s2  <= '0;
            m_s3  <= '0;
            m_br  <= 0;
            m_mis <= 0;
        end else if (!memory_stall) begin
            if (m_s3.v) begin
                if (ref_eval(m_s3, rs1_data_3, rs2_data_3).is_br && m_br < CNT_MAX) m_br <= m_br + 1;
                if (ref_eval(m_s3, rs1_data_3, rs2_data_3).mis   && m_mis < CNT_MAX) m_mis <= m_mis + 1;
            end
            m_s2 <= '{v: !flush, pc: pc_1, instr: instr_1, pt: pred_taken_1, ptgt: pred_target_1};
            m_s3 <= m_s2;
            m_s3.v <= m_s2.v && !flush;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_model();
        res_t e;
        e = ref_eval(m_s3, rs1_data_3, rs2_data_3);
        check("pc3",     instructionPC_3, m_s3.v ? m_s3.pc : 32'd0);
        check("is_br3",  32'(is_branchInst_3), 32'(e.is_br));
        check("prev3",   32'(prev_taken_3), 32'(m_s3.v & m_s3.pt));
        check("taken3",  32'(taken_3), 32'(e.taken));
        check("target3", target_3, e.target);
        check("mis3",    32'(mispredict_3), 32'(e.mis));
        check("brcnt",   32'(branch_cnt), 32'(m_br));
        check("miscnt",  32'(mispred_cnt), 32'(m_mis));
    endtask

    // One cycle: drive inputs after the falling edge, check before the rising edge.
    task automatic drive(input logic st, input logic fl, input logic [31:0] pc,
                         input logic [31:0] ins, input logic pt, input logic [31:0] ptgt,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        memory_stall  = st;
        flush         = fl;
        pc_1          = pc;
        instr_1       = ins;
        pred_taken_1  = pt;
        pred_target_1 = ptgt;
        rs1_data_3    = a;
        rs2_data_3    = b;
        #1;
        check_model();
    endtask

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [2:0] f3);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
    endfunction

    task automatic drive_random();
        logic [31:0] r, pc, ins, a, b, pt_tgt;
        int          kind;
        r = $urandom();
        pc = {r[31:2], 2'b00};
        ins = $urandom();
        kind = $urandom_range(0, 5);
        case (kind)
            0, 1:    ins[6:0] = 7'b1100011;
            2:       ins[6:0] = 7'b1101111;
            3:       ins[6:0] = 7'b1100111;
            4:       ins[6:0] = 7'b0010011;
            default: ;
        endcase
        a = $urandom();
        b = ($urandom_range(0, 2) == 0) ? a : 32'($urandom());
        if ($urandom_range(0, 3) == 0) begin
            a = 32'($urandom_range(0, 3)) - 32'd2;
            b = 32'($urandom_range(0, 3)) - 32'd2;
        end
        pt_tgt = ($urandom_range(0, 1) == 1) ? br_target(pc, ins) : 32'($urandom());
        drive($urandom_range(0, 6) == 0, $urandom_range(0, 7) == 0, pc, ins,
              1'($urandom_range(0, 1)), pt_tgt, a, b);
    endtask

    initial begin
        // Power-on reset
        repeat (2) @(negedge clk);
        #1;
        check("rst_pc3", instructionPC_3, 32'd0);
        check("rst_cnt", 32'(branch_cnt) | 32'(mispred_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // BEQ at 0x100, predicted not-taken, held in stage 3 by a stall with flush
        drive(0, 0, 32'h100, enc_b(13'h040, 3'b000), 0, 32'd0, 0, 0);
        drive(0, 0, 32'h104, NOP, 0, 32'd0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 32'h108, NOP, 0, 32'd0, 32'd5, 32'd5);
            check("beq_taken", 32'(taken_3), 32'd1);
            check("beq_target", target_3, 32'h140);
            check("beq_mis", 32'(mispredict_3), 32'd1);
            check("stall_pc3", instructionPC_3, 32'h100);
            check("stall_miscnt", 32'(mispred_cnt), 32'd0);
        end
        drive(0, 1, 32'h108, NOP, 0, 32'd0, 32'd5, 32'd5);
        drive(0, 0, 32'h500, NOP, 0, 32'd0, 0, 0);
        check("squash1_pc3", instructionPC_3, 32'd0);
        check("beq_miscnt", 32'(mispred_cnt), 32'd1);
        check("beq_brcnt", 32'(branch_cnt), 32'd1);
        drive(0, 0, 32'h504, NOP, 0, 32'd0, 0, 0);
        check("squash2_v3", 32'(is_branchInst_3) | instructionPC_3, 32'd0);

        // BLT vs BLTU on the same operands
        drive(0, 0, 32'h300, enc_b(13'h080, 3'b100), 1, 32'h380, 0, 0);
        drive(0, 0, 32'h400, enc_b(13'h080, 3'b110), 0, 32'd0, 0, 0);
        drive(0, 0, 32'h508, NOP, 0, 32'd0, 32'hFFFF_FFFF, 32'd1);
        check("blt_taken", 32'(taken_3), 32'd1);
        check("blt_target", target_3, 32'h380);
        drive(0, 0, 32'h50C, NOP, 0, 32'd0, 32'hFFFF_FFFF, 32'd1);
        check("bltu_taken", 32'(taken_3), 32'd0);
        check("bltu_target", target_3, 32'h404);

        // Non-branch predicted taken
        drive(0, 0, 32'h200, NOP, 1, 32'h1234, 0, 0);
        drive(0, 0, 32'h510, NOP, 0, 32'd0, 0, 0);
        drive(0, 0, 32'h514, NOP, 0, 32'd0, 0, 0);
        check("addi_isbr", 32'(is_branchInst_3), 32'd0);
        check("addi_prev", 32'(prev_taken_3), 32'd1);
        check("addi_taken", 32'(taken_3), 32'd0);
        check("addi_target", target_3, 32'h204);
        check("addi_mis", 32'(mispredict_3), 32'd1);
        check("addi_brcnt", 32'(branch_cnt), 32'd3);

        // JAL wrapping past 2^32
        drive(0, 0, 32'hFFFF_FFF0, enc_j(21'h20), 1, 32'h10, 0, 0);
        drive(0, 0, 32'h518, NOP, 0, 32'd0, 0, 0);
        drive(0, 0, 32'h51C, NOP, 0, 32'd0, 0, 0);
        check("jal_taken", 32'(taken_3), 32'd1);
        check("jal_wrap", target_3, 32'h10);
        check("jal_mis", 32'(mispredict_3), 32'd0);

        // Saturation: 20 mispredicted JALs
        for (int i = 0; i < 20; i++)
            drive(0, 0, 32'h600 + 32'(i * 4), enc_j(21'h100), 0, 32'd0, 0, 0);
        drive(0, 0, 32'h520, NOP, 0, 32'd0, 0, 0);
        drive(0, 0, 32'h524, NOP, 0, 32'd0, 0, 0);
        check("sat_brcnt", 32'(branch_cnt), 32'd15);
        check("sat_miscnt", 32'(mispred_cnt), 32'd15);

        // Randomized traffic against the reference model
        for (int i = 0; i < 2000; i++) drive_random();

        // Asynchronous reset mid-cycle while a BEQ sits in stage 3
        drive(0, 0, 32'h700, enc_b(13'h008, 3'b000), 0, 32'd0, 0, 0);
        drive(0, 0, 32'h704, NOP, 0, 32'd0, 0, 0);
        drive(1, 1, 32'h708, NOP, 0, 32'd0, 32'd3, 32'd3);
        check("pre_rst_isbr", 32'(is_branchInst_3), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_pc3", instructionPC_3, 32'd0);
        check("arst_flags", {28'd0, is_branchInst_3, taken_3, prev_taken_3, mispredict_3}, 32'd0);
        check("arst_target", target_3, 32'd0);
        check("arst_cnt", 32'(branch_cnt) | 32'(mispred_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) drive_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
